// File: rtl/protected_access_guard.sv
// Bus guard: rejects writes below a protection boundary and times out stalled slaves.
// Define PROTECTED_GUARD_READ_EN to also reject reads below the boundary.
module protected_access_guard #(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 protected_flag,
  input  logic [BUS_WIDTH-1:0] protected_addr,
  input  logic                 m_req,
  input  logic                 m_we,
  input  logic [BUS_WIDTH-1:0] m_addr,
  input  logic [BUS_WIDTH-1:0] m_wdata,
  output logic                 m_ack,
  output logic [BUS_WIDTH-1:0] m_rdata,
  output logic                 m_fault,
  output logic                 s_req,
  output logic                 s_we,
  output logic [BUS_WIDTH-1:0] s_addr,
  output logic [BUS_WIDTH-1:0] s_wdata,
  input  logic                 s_ack,
  input  logic [BUS_WIDTH-1:0] s_rdata,
  output logic [BUS_WIDTH-1:0] fault_addr,
  output logic                 fault_cause,
  output logic [7:0]           fault_count
);

`ifdef PROTECTED_GUARD_READ_EN
  localparam logic CHECK_READS = 1'b1;
`else
  localparam logic CHECK_READS = 1'b0;
`endif

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    FAULT
  } state_t;

  state_t               state_q;
  logic [7:0]           wait_q;
  logic                 m_ack_q;
  logic                 m_fault_q;
  logic [BUS_WIDTH-1:0] m_rdata_q;
  logic                 s_req_q;
  logic                 s_we_q;
  logic [BUS_WIDTH-1:0] s_addr_q;
  logic [BUS_WIDTH-1:0] s_wdata_q;
  logic [BUS_WIDTH-1:0] fault_addr_q;
  logic                 fault_cause_q;
  logic [7:0]           fault_count_q;
  logic [7:0]           fault_count_d;
  logic                 deny_d;

  always_comb begin
    deny_d = protected_flag
           && (m_addr < protected_addr)
           && (m_we || CHECK_READS);
    fault_count_d = fault_count_q;
    if (fault_count_q != 8'hFF) begin
      fault_count_d = fault_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      m_ack_q       <= 1'b0;
      m_fault_q     <= 1'b0;
      m_rdata_q     <= '0;
      s_req_q       <= 1'b0;
      s_we_q        <= 1'b0;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
      fault_addr_q  <= '0;
      fault_cause_q <= 1'b0;
      fault_count_q <= '0;
    end else begin
      m_ack_q   <= 1'b0;
      m_fault_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (m_req) begin
            s_we_q    <= m_we;
            s_addr_q  <= m_addr;
            s_wdata_q <= m_wdata;
            wait_q    <= '0;
            if (deny_d) begin
              state_q       <= FAULT;
              m_ack_q       <= 1'b1;
              m_fault_q     <= 1'b1;
              m_rdata_q     <= '0;
              fault_addr_q  <= m_addr;
              fault_cause_q <= 1'b0;
              fault_count_q <= fault_count_d;
            end else begin
              state_q <= BUSY;
              s_req_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          // A late ack on the expiry cycle still completes normally
          if (s_ack) begin
            state_q   <= RESP;
            s_req_q   <= 1'b0;
            m_ack_q   <= 1'b1;
            m_rdata_q <= s_rdata;
          end else if (wait_q == WAIT_LAST) begin
            state_q       <= FAULT;
            s_req_q       <= 1'b0;
            m_ack_q       <= 1'b1;
            m_fault_q     <= 1'b1;
            m_rdata_q     <= '0;
            fault_addr_q  <= s_addr_q;
            fault_cause_q <= 1'b1;
            fault_count_q <= fault_count_d;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        FAULT: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_ack       = m_ack_q;
  assign m_fault     = m_fault_q;
  assign m_rdata     = m_rdata_q;
  assign s_req       = s_req_q;
  assign s_we        = s_we_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign fault_addr  = fault_addr_q;
  assign fault_cause = fault_cause_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_protected_access_guard.sv
// Randomized bench for protected_access_guard against a transaction-level model.
// Honours PROTECTED_GUARD_READ_EN the same way as the design.
module tb_protected_access_guard;

  localparam int BW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          nreset;
  logic          protected_flag;
  logic [BW-1:0] protected_addr;
  logic          m_req;
  logic          m_we;
  logic [BW-1:0] m_addr;
  logic [BW-1:0] m_wdata;
  logic          m_ack;
  logic [BW-1:0] m_rdata;
  logic          m_fault;
  logic          s_req;
  logic          s_we;
  logic [BW-1:0] s_addr;
  logic [BW-1:0] s_wdata;
  logic          s_ack;
  logic [BW-1:0] s_rdata;
  logic [BW-1:0] fault_addr;
  logic          fault_cause;
  logic [7:0]    fault_count;

  int checks = 0;
  int errors = 0;

  int            mdl_cnt;
  logic [BW-1:0] mdl_faddr;
  logic          mdl_cause;

  always #5 clk = ~clk;

  protected_access_guard #(
    .BUS_WIDTH     (BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .protected_flag(protected_flag),
    .protected_addr(protected_addr),
    .m_req         (m_req),
    .m_we          (m_we),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_ack         (m_ack),
    .m_rdata       (m_rdata),
    .m_fault       (m_fault),
    .s_req         (s_req),
    .s_we          (s_we),
    .s_addr        (s_addr),
    .s_wdata       (s_wdata),
    .s_ack         (s_ack),
    .s_rdata       (s_rdata),
    .fault_addr    (fault_addr),
    .fault_cause   (fault_cause),
    .fault_count   (fault_count)
  );

  typedef struct {
    bit          flag;
    logic [31:0] bnd;
    bit          we;
    logic [31:0] addr;
    int          dly;
    logic [31:0] rd;
  } txn_t;

  function automatic bit denied(bit flag, logic [31:0] bnd,
                                bit we, logic [31:0] addr);
    bit rd_chk;
`ifdef PROTECTED_GUARD_READ_EN
    rd_chk = 1'b1;
`else
    rd_chk = 1'b0;
`endif
    return flag && (addr < bnd) && (we || rd_chk);
  endfunction

  // Drives one request, plays the slave (acks on the dly+1'th s_req cycle),
  // and records what the master side sees.
  task automatic run_txn(input txn_t t, input logic [31:0] wd,
                         output bit acked, output bit flt,
                         output logic [31:0] rdata, output int nsreq,
                         output int cyc, output bit bad);
    @(negedge clk);
    protected_flag = t.flag;
    protected_addr = t.bnd;
    m_req = 1'b1;
    m_we = t.we;
    m_addr = t.addr;
    m_wdata = wd;
    s_ack = 1'b0;
    @(negedge clk);
    m_req = 1'b0;
    m_we = 1'($urandom);
    m_addr = $urandom;
    protected_flag = 1'($urandom);
    protected_addr = $urandom;
    acked = 0; flt = 0; rdata = '0;
    nsreq = 0; cyc = 0; bad = 0;
    for (int i = 1; i <= 40 && !acked; i++) begin
      s_ack = 1'b0;
      s_rdata = $urandom;
      if (s_req && m_ack) bad = 1;
      if (m_ack) begin
        acked = 1; flt = m_fault; rdata = m_rdata; cyc = i;
      end else begin
        if (s_req) begin
          nsreq++;
          if (s_addr !== t.addr || s_we !== t.we || s_wdata !== wd)
            bad = 1;
          if (nsreq == t.dly + 1) begin
            s_ack = 1'b1;
            s_rdata = t.rd;
          end
        end
        @(negedge clk);
      end
    end
    s_ack = 1'b0;
    if (acked) begin
      @(negedge clk);
      if (m_ack !== 1'b0 || s_req !== 1'b0) bad = 1;
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    protected_flag = 0; protected_addr = '0;
    s_ack = 0; s_rdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_ack, m_fault, m_rdata, s_req, s_we, s_addr, s_wdata,
         fault_addr, fault_cause} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%0b flt=%0b rd=%h sreq=%0b saddr=%h",
               m_ack, m_fault, m_rdata, s_req, s_addr);
    end
    checks++;
    if (fault_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", fault_count);
    end
    nreset = 1'b1;
    mdl_cnt = 0; mdl_faddr = '0; mdl_cause = 0;
  endtask

  task automatic check_txn(input string nm, input txn_t t);
    bit acked, flt, bad, e_deny, e_to, e_flt;
    logic [31:0] rdata, wd, e_rd;
    int nsreq, cyc, e_n;
    wd = $urandom;
    e_deny = denied(t.flag, t.bnd, t.we, t.addr);
    e_to = !e_deny && (t.dly + 1 > TO);
    e_flt = e_deny || e_to;
    e_n = e_deny ? 0 : (e_to ? TO : t.dly + 1);
    e_rd = e_flt ? 32'h0 : t.rd;
    if (e_flt) begin
      mdl_faddr = t.addr;
      mdl_cause = e_to;
      if (mdl_cnt < 255) mdl_cnt++;
    end
    run_txn(t, wd, acked, flt, rdata, nsreq, cyc, bad);
    checks++;
    if (!acked || bad || flt !== e_flt || rdata !== e_rd
        || nsreq != e_n || cyc != e_n + 1) begin
      errors++;
      $display("FAIL %s resp: ack=%0b bad=%0b flt=%0b rd=%h n=%0d cyc=%0d want flt=%0b rd=%h n=%0d cyc=%0d",
               nm, acked, bad, flt, rdata, nsreq, cyc, e_flt, e_rd, e_n, e_n + 1);
    end
    checks++;
    if (fault_addr !== mdl_faddr || fault_cause !== mdl_cause
        || fault_count !== 8'(mdl_cnt)) begin
      errors++;
      $display("FAIL %s fault_regs: addr=%h cause=%0b cnt=%0d want %h %0b %0d",
               nm, fault_addr, fault_cause, fault_count,
               mdl_faddr, mdl_cause, mdl_cnt);
    end
  endtask

  task automatic test_directed();
    txn_t tab[10];
    tab[0] = '{1, 3, 1, 2, 0, 32'h11};
    tab[1] = '{1, 3, 1, 3, 1, 32'h22};
    tab[2] = '{0, 0, 1, 0, 0, 32'hA5};
    tab[3] = '{1, 3, 0, 1, 0, 32'h5A};
    tab[4] = '{0, 0, 0, 8, 30, 32'h33};
    tab[5] = '{0, 0, 1, 4, TO - 1, 32'h44};
    tab[6] = '{0, 0, 1, 4, TO, 32'h55};
    tab[7] = '{1, 32'h8000_0000, 1, 32'h7FFF_FFFF, 0, 32'h66};
    tab[8] = '{1, 32'h8000_0000, 1, 32'h8000_0000, 2, 32'h77};
    tab[9] = '{1, 0, 1, 0, 0, 32'h88};
    foreach (tab[i]) check_txn($sformatf("dir%0d", i), tab[i]);
  endtask

  task automatic test_random();
    txn_t t;
    for (int i = 0; i < 60; i++) begin
      t.flag = 1'($urandom);
      t.bnd = $urandom_range(0, 8);
      t.we = 1'($urandom);
      t.addr = $urandom_range(0, 8);
      t.dly = $urandom_range(0, TO + 2);
      t.rd = $urandom;
      check_txn($sformatf("rnd%0d", i), t);
    end
  endtask

  task automatic test_saturation();
    txn_t t;
    for (int i = 0; i < 260; i++) begin
      t = '{1, 32'd100, 1, 32'($urandom_range(0, 99)), 0, 32'h0};
      check_txn($sformatf("sat%0d", i), t);
    end
    checks++;
    if (fault_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate: got %0d want 255", fault_count);
    end
  endtask

  task automatic test_reset_busy();
    txn_t t;
    bit saw_ack;
    @(negedge clk);
    protected_flag = 0; m_req = 1; m_we = 1;
    m_addr = 32'h40; m_wdata = 32'h1234; s_ack = 0;
    @(negedge clk);
    m_req = 0;
    checks++;
    if (s_req !== 1'b1) begin
      errors++;
      $display("FAIL busy_sreq: got %0b want 1", s_req);
    end
    nreset = 1'b0;
    @(negedge clk);
    checks++;
    if (s_req !== 1'b0 || m_ack !== 1'b0 || fault_count !== 8'd0
        || fault_addr !== '0) begin
      errors++;
      $display("FAIL busy_reset: sreq=%0b ack=%0b cnt=%0d faddr=%h want 0 0 0 0",
               s_req, m_ack, fault_count, fault_addr);
    end
    nreset = 1'b1;
    mdl_cnt = 0; mdl_faddr = '0; mdl_cause = 0;
    saw_ack = 0;
    s_ack = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (m_ack || s_req) saw_ack = 1;
    end
    s_ack = 1'b0;
    checks++;
    if (saw_ack) begin
      errors++;
      $display("FAIL abort_silent: got ack/sreq=1 want 0");
    end
    t = '{0, 0, 0, 32'h10, 3, 32'hCAFE};
    check_txn("post_reset", t);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_saturation();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
